// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//   Shares a single FIFO write port among CH producer channels. A round-robin
//   scan picks the next owner starting one past the previous owner. The owner
//   keeps the port for up to MAX_BURST beats, or until it drops valid. Each
//   release costs one idle bubble cycle. The arbiter never writes while the
//   FIFO reports full.
//
// Ports:
//   clk_i         clock; all logic runs on the rising edge
//   srst_i        synchronous reset, active high
//   ch_data_i     CH*DWIDTH packed producer data; channel k at [k*DWIDTH +: DWIDTH]
//   ch_valid_i    per-channel "beat available"
//   ch_ready_o    per-channel "beat accepted this cycle when valid"
//   fifo_data_o   write data to the FIFO; 0 when not writing
//   fifo_wrreq_o  write strobe to the FIFO
//   fifo_full_i   FIFO full flag
//   grant_o       one-hot current owner; 0 when idle
//   grant_id_o    index of the current owner; 0 when idle
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int CH        = 4,
  parameter int DWIDTH    = 64,
  parameter int MAX_BURST = 8,
  localparam int IDW      = $clog2(CH),
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [CH*DWIDTH-1:0] ch_data_i,
  input  logic [CH-1:0]        ch_valid_i,
  output logic [CH-1:0]        ch_ready_o,
  output logic [DWIDTH-1:0]    fifo_data_o,
  output logic                 fifo_wrreq_o,
  input  logic                 fifo_full_i,
  output logic [CH-1:0]        grant_o,
  output logic [IDW-1:0]       grant_id_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  owner_reg, owner_next;
  logic [IDW-1:0]  last_reg, last_next;
  logic [CW-1:0]   burst_cnt_reg, burst_cnt_next;

  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  logic            owner_valid;
  logic [DWIDTH-1:0] owner_data;
  logic            burst_last;

  // Round-robin scan: offsets are visited from farthest to nearest so the
  // last hit (the nearest valid channel after last_reg) wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = CH; k >= 1; k--) begin
      idx = (int'(last_reg) + k) % CH;
      if (ch_valid_i[idx]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  assign owner_valid = ch_valid_i[owner_reg];
  assign owner_data  = ch_data_i[int'(owner_reg)*DWIDTH +: DWIDTH];
  assign burst_last  = (burst_cnt_reg == CW'(MAX_BURST - 1));

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    burst_cnt_next = burst_cnt_reg;
    ch_ready_o     = '0;
    fifo_wrreq_o   = 1'b0;
    fifo_data_o    = '0;
    grant_o        = '0;
    grant_id_o     = '0;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          owner_next     = pick_id;
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        grant_o[owner_reg]    = 1'b1;
        grant_id_o            = owner_reg;
        ch_ready_o[owner_reg] = !fifo_full_i;
        if (owner_valid && !fifo_full_i) begin
          fifo_wrreq_o   = 1'b1;
          fifo_data_o    = owner_data;
          burst_cnt_next = burst_cnt_reg + 1'b1;
          if (burst_last) begin
            last_next  = owner_reg;
            state_next = IDLE;
          end
        end else if (!owner_valid) begin
          // Producer went idle: forfeit the grant without a beat.
          last_next  = owner_reg;
          state_next = IDLE;
        end
        // Full with valid held: stall, counter frozen, grant kept.
      end
      default: state_next = IDLE;
    endcase

    // Reset blanks every output in the same cycle so no beat escapes.
    if (srst_i) begin
      ch_ready_o   = '0;
      fifo_wrreq_o = 1'b0;
      fifo_data_o  = '0;
      grant_o      = '0;
      grant_id_o   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      last_reg      <= IDW'(CH - 1);
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Randomized bench for fifo_wr_arbiter. Producers emit tagged beats
// ({channel, pattern, sequence}); the FIFO is a queue of depth 16 that drains
// at random. A cycle-level reference of the arbitration rules predicts every
// output, and the drained FIFO contents are checked for per-channel order
// and completeness.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  localparam int CH    = 4;
  localparam int DW    = 64;
  localparam int MB    = 8;
  localparam int IDW   = 2;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            srst;
  logic [CH*DW-1:0] ch_data;
  logic [CH-1:0]   ch_valid;
  logic [CH-1:0]   ch_ready;
  logic [DW-1:0]   fifo_data;
  logic            fifo_wrreq;
  logic            fifo_full;
  logic [CH-1:0]   grant;
  logic [IDW-1:0]  grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.CH(CH), .DWIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i        (clk),
    .srst_i       (srst),
    .ch_data_i    (ch_data),
    .ch_valid_i   (ch_valid),
    .ch_ready_o   (ch_ready),
    .fifo_data_o  (fifo_data),
    .fifo_wrreq_o (fifo_wrreq),
    .fifo_full_i  (fifo_full),
    .grant_o      (grant),
    .grant_id_o   (grant_id)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: owner of the port (-1 = idle), previous owner, beats so far.
  int m_owner = -1;
  int m_last  = CH - 1;
  int m_beats = 0;

  int          seq     [CH];   // next sequence number each producer offers
  int          pop_seq [CH];   // next sequence number expected out of the FIFO
  logic [DW-1:0] fifo_q [$];
  logic [CH-1:0] vld;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] tag_of(input int ch, input int s);
    return {8'(ch), 24'hC0FFEE, 32'(s)};
  endfunction

  // One clock cycle. Entered at posedge+1, leaves at the next posedge+1.
  task automatic run_cycle(input bit rst, input int pvalid, input int pkeep, input int pdrain);
    logic [CH-1:0] e_ready, e_grant;
    logic [DW-1:0] e_data, popped;
    logic          e_wr, xfer;
    int            e_id, pc;

    srst      = rst;
    fifo_full = (fifo_q.size() >= DEPTH);
    for (int k = 0; k < CH; k++) begin
      if (vld[k]) vld[k] = ($urandom_range(99) < pkeep);
      else        vld[k] = ($urandom_range(99) < pvalid);
      ch_data[k*DW +: DW] = tag_of(k, seq[k]);
    end
    ch_valid = vld;

    @(negedge clk);

    e_ready = '0; e_grant = '0; e_data = '0; e_wr = 1'b0; e_id = 0; xfer = 1'b0;
    if (!rst && m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_id             = m_owner;
      e_ready[m_owner] = !fifo_full;
      xfer             = vld[m_owner] && !fifo_full;
      if (xfer) begin
        e_wr   = 1'b1;
        e_data = tag_of(m_owner, seq[m_owner]);
      end
    end

    check_eq("grant",    64'(grant),      64'(e_grant));
    check_eq("grant_id", 64'(grant_id),   64'(e_id));
    check_eq("ready",    64'(ch_ready),   64'(e_ready));
    check_eq("wrreq",    64'(fifo_wrreq), 64'(e_wr));
    check_eq("data",     fifo_data,       e_data);

    // Advance the reference to the next edge.
    if (rst) begin
      m_owner = -1; m_last = CH - 1; m_beats = 0;
    end else if (m_owner < 0) begin
      pc = -1;
      for (int k = CH; k >= 1; k--)
        if (vld[(m_last + k) % CH]) pc = (m_last + k) % CH;
      if (pc >= 0) begin
        m_owner = pc; m_beats = 0;
      end
    end else if (xfer) begin
      seq[m_owner]++;
      m_beats++;
      if (m_beats == MB) begin
        m_last = m_owner; m_owner = -1;
      end
    end else if (!vld[m_owner]) begin
      m_last = m_owner; m_owner = -1;
    end

    // FIFO side: pop first, then capture whatever the DUT actually wrote.
    if (fifo_q.size() > 0 && $urandom_range(99) < pdrain) begin
      popped = fifo_q.pop_front();
      pc = int'(popped[63:56]);
      if (pc < CH) begin
        check_eq("order", 64'(popped[31:0]), 64'(pop_seq[pc]));
        pop_seq[pc] = int'(popped[31:0]) + 1;
      end else begin
        check_eq("tag_ch", 64'(pc), 64'(CH - 1));
      end
    end
    if (fifo_wrreq) begin
      if (fifo_full) check_eq("overflow", 64'(fifo_q.size()), 64'(DEPTH - 1));
      fifo_q.push_back(fifo_data);
      $display("[TB] write ch%0d seq%0d full_seen=%0d", fifo_data[63:56], fifo_data[31:0], fifo_full);
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    srst = 1'b1; ch_valid = '0; ch_data = '0; fifo_full = 1'b0;
    vld = '0;
    for (int k = 0; k < CH; k++) begin seq[k] = 0; pop_seq[k] = 0; end
    @(posedge clk); #1;

    // Reset with every producer requesting: outputs must stay quiet.
    vld = '1;
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 100, 100, 100);

    // All channels busy, FIFO never full: steady round-robin bursts of 8.
    for (int i = 0; i < 300; i++) run_cycle(1'b0, 100, 100, 100);

    // Sparse producers, slow drain: frequent full stalls and forfeits.
    for (int i = 0; i < 800; i++) run_cycle(1'b0, 40, 85, 30);

    // Busier traffic with occasional mid-burst resets.
    for (int i = 0; i < 400; i++) run_cycle($urandom_range(149) == 0, 70, 95, 60);

    // Single requester: re-granted after each release with a bubble only.
    for (int i = 0; i < 60; i++) begin
      vld[0] = 1'b0; vld[1] = 1'b0; vld[3] = 1'b0;
      run_cycle(1'b0, 0, 100, 100);
      vld[2] = 1'b1;
    end

    // Drain: no producers, empty the FIFO, then check nothing was lost.
    vld = '0;
    for (int i = 0; i < 60; i++) run_cycle(1'b0, 0, 0, 100);
    check_eq("fifo_empty", 64'(fifo_q.size()), 64'd0);
    for (int k = 0; k < CH; k++)
      check_eq($sformatf("count_ch%0d", k), 64'(pop_seq[k]), 64'(seq[k]));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
